// File: rtl/jnwatr_trim_sar.sv
// Successive-approximation trim calibrator: binary-searches a segment-enable code against a comparator.
// Optional feature: define JNWATR_TRIM_OVERRIDE_EN to add a direct code override (ovr, ovr_code).
module jnwatr_trim_sar #(
  parameter int NBITS  = 6,
  parameter int SETTLE = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             start,
  input  logic             abort,
  input  logic             cmp,
`ifdef JNWATR_TRIM_OVERRIDE_EN
  input  logic             ovr,
  input  logic [NBITS-1:0] ovr_code,
`endif
  output logic [NBITS-1:0] trim,
  output logic             busy,
  output logic             done,
  output logic             valid
);

  localparam int CW = 8;
  localparam int IW = (NBITS > 1) ? $clog2(NBITS) : 1;
  localparam logic [NBITS-1:0] MID = NBITS'(1) << (NBITS - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETTLE,
    S_DECIDE,
    S_FINISH
  } state_t;

  state_t           state_q, state_d;
  logic [NBITS-1:0] trim_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             valid_d;
  logic             cmp_meta, cmps;

  // cmp is asynchronous to clk; only the second flop's output is trusted.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      cmp_meta <= 1'b0;
      cmps     <= 1'b0;
    end else begin
      cmp_meta <= cmp;
      cmps     <= cmp_meta;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= S_IDLE;
      trim    <= MID;
      idx_q   <= '0;
      cnt_q   <= '0;
      valid   <= 1'b0;
    end else begin
      state_q <= state_d;
      trim    <= trim_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      valid   <= valid_d;
    end
  end

  // NOTE: every signal gets a default first so no path through the case infers a latch.
  always_comb begin
    state_d = state_q;
    trim_d  = trim;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    valid_d = valid;
    if (abort) begin
      state_d = S_IDLE;
      trim_d  = MID;
      valid_d = 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            state_d = S_SETTLE;
            trim_d  = MID;
            idx_d   = IW'(NBITS - 1);
            cnt_d   = CW'(SETTLE - 1);
            valid_d = 1'b0;
          end
`ifdef JNWATR_TRIM_OVERRIDE_EN
          else if (ovr) begin
            trim_d  = ovr_code;
            valid_d = 1'b1;
          end
`endif
        end
        S_SETTLE: begin
          if (cnt_q == '0) state_d = S_DECIDE;
          else             cnt_d   = cnt_q - CW'(1);
        end
        S_DECIDE: begin
          // Bank above target: this segment overshoots, drop it.
          if (cmps) trim_d[idx_q] = 1'b0;
          if (idx_q == '0) begin
            state_d = S_FINISH;
          end else begin
            idx_d                  = idx_q - IW'(1);
            trim_d[idx_q - IW'(1)] = 1'b1;
            cnt_d                  = CW'(SETTLE - 1);
            state_d                = S_SETTLE;
          end
        end
        S_FINISH: begin
          state_d = S_IDLE;
          valid_d = 1'b1;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  assign busy = (state_q == S_SETTLE) || (state_q == S_DECIDE);
  // An abort coinciding with FINISH suppresses the completion pulse.
  assign done = (state_q == S_FINISH) && !abort;

endmodule

// File: tb/tb_jnwatr_trim_sar.sv
// Self-checking bench for jnwatr_trim_sar: vector table of calibrations plus abort/reset/back-to-back sequences.
module tb_jnwatr_trim_sar;

  localparam int NBITS  = 6;
  localparam int SETTLE = 8;
  localparam int LAT    = NBITS * (SETTLE + 1) + 1;

  logic             clk = 1'b0;
  logic             rstn = 1'b0;
  logic             start = 1'b0;
  logic             abort = 1'b0;
  logic             cmp;
  logic [NBITS-1:0] trim;
  logic             busy, done, valid;
  logic [NBITS-1:0] target = 6'd37;
`ifdef JNWATR_TRIM_OVERRIDE_EN
  logic             ovr = 1'b0;
  logic [NBITS-1:0] ovr_code = '0;
`endif

  jnwatr_trim_sar #(.NBITS(NBITS), .SETTLE(SETTLE)) dut (
    .clk     (clk),
    .rstn    (rstn),
    .start   (start),
    .abort   (abort),
    .cmp     (cmp),
`ifdef JNWATR_TRIM_OVERRIDE_EN
    .ovr     (ovr),
    .ovr_code(ovr_code),
`endif
    .trim    (trim),
    .busy    (busy),
    .done    (done),
    .valid   (valid)
  );

  always #5 clk = ~clk;

  // Comparator model: bank output is above target when the code exceeds it.
  assign cmp = (trim > target);

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [NBITS-1:0] code;
    int               edge_n;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    logic [NBITS-1:0] target;
    logic [NBITS-1:0] code;
    bit               extra;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  // Scoreboard: every DONE pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rstn && done) begin
      if (sb.size() == 0) fail("spurious_done");
      else begin
        exp_t e;
        e = sb.pop_front();
        check("done_code", 32'(trim), 32'(e.code));
        check("done_edge", cyc + 1, e.edge_n);
      end
    end
  end

  task automatic run_cal(input vec_t v, input bit check_trials);
    int k;
    bit seen;
    logic [NBITS-1:0] last;
    logic [NBITS-1:0] trials[$];
    logic [NBITS-1:0] seq63[6];
    seq63 = '{6'd32, 6'd48, 6'd56, 6'd60, 6'd62, 6'd63};
    target = v.target;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    k = cyc;
    check("accept_busy", busy, 1);
    check("accept_valid_clr", valid, 0);
    sb.push_back('{v.code, k + LAT});
    last = trim;
    trials.delete();
    trials.push_back(trim);
    seen = 1'b0;
    for (int i = 0; i < 300 && !seen; i++) begin
      @(negedge clk);
      start = v.extra && busy && (i % 7 == 3);
`ifdef JNWATR_TRIM_OVERRIDE_EN
      ovr      = v.extra && busy && (i % 5 == 1);
      ovr_code = 6'd5;
`endif
      if (trim !== last) begin
        trials.push_back(trim);
        last = trim;
      end
      if (done) seen = 1'b1;
    end
    start = 1'b0;
`ifdef JNWATR_TRIM_OVERRIDE_EN
    ovr = 1'b0;
`endif
    if (!seen) begin
      fail("done_timeout");
      sb.delete();
    end else begin
      check("done_not_busy", busy, 0);
      @(negedge clk);
      check("done_one_cycle", done, 0);
      check("valid_after_done", valid, 1);
      check("trim_hold", 32'(trim), 32'(v.code));
    end
    if (check_trials) begin
      check("trial_count", trials.size(), 6);
      for (int j = 0; j < 6 && j < trials.size(); j++)
        check("trial_code", 32'(trials[j]), 32'(seq63[j]));
    end
  endtask

  vec_t vecs[6];

  initial begin
    int k, n_done;
    bit hit;

    vecs[0] = '{6'd37, 6'd37, 1'b0};
    vecs[1] = '{6'd0,  6'd0,  1'b0};
    vecs[2] = '{6'd63, 6'd63, 1'b0};
    vecs[3] = '{6'd21, 6'd21, 1'b1};
    vecs[4] = '{6'd1,  6'd1,  1'b0};
    vecs[5] = '{6'd62, 6'd62, 1'b1};

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_trim", 32'(trim), 32);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_valid", valid, 0);
    rstn = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 6; i++) run_cal(vecs[i], vecs[i].target == 6'd63);

    // Abort in IDLE clears VALID and restores midscale
    run_cal(vecs[0], 1'b0);
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_idle_valid", valid, 0);
    check("abort_idle_trim", 32'(trim), 32);

    // Abort during the bit-3 trial (TRIM=40 under target 37)
    target = 6'd37;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    sb.push_back('{6'd37, cyc + LAT});
    hit = 1'b0;
    for (int i = 0; i < 100 && !hit; i++) begin
      if (trim == 6'd40 && busy) hit = 1'b1;
      else @(negedge clk);
    end
    if (!hit) fail("abort_wait_bit3");
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    sb.delete();
    check("abort_trim", 32'(trim), 32);
    check("abort_busy", busy, 0);
    check("abort_valid", valid, 0);
    n_done = 0;
    for (int i = 0; i < 70; i++) begin
      @(negedge clk);
      if (done) n_done++;
    end
    check("abort_no_done", n_done, 0);

    // Reset mid-calibration, then a normal calibration
    target = 6'd37;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    sb.push_back('{6'd37, cyc + LAT});
    repeat (20) @(negedge clk);
    rstn = 1'b0;
    sb.delete();
    @(negedge clk);
    check("midrst_trim", 32'(trim), 32);
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    check("midrst_valid", valid, 0);
    rstn = 1'b1;
    run_cal('{6'd21, 6'd21, 1'b0}, 1'b0);

    // START held high: back-to-back calibrations, DONE every NBITS*(SETTLE+1)+2 edges
    target = 6'd37;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    k = cyc;
    check("b2b_accept", busy, 1);
    for (int j = 0; j < 3; j++) sb.push_back('{6'd37, k + LAT + j * (LAT + 1)});
    n_done = 0;
    for (int i = 0; i < 400 && n_done < 3; i++) begin
      @(negedge clk);
      if (done) n_done++;
    end
    start = 1'b0;
    check("b2b_done_count", n_done, 3);
    if (n_done < 3) sb.delete();
    repeat (3) @(negedge clk);
    check("b2b_stopped", busy, 0);
    check("b2b_valid", valid, 1);

`ifdef JNWATR_TRIM_OVERRIDE_EN
    // Override in IDLE, then ignored while busy (vector with extra=1 drives ovr)
    @(negedge clk);
    ovr      = 1'b1;
    ovr_code = 6'd17;
    @(negedge clk);
    ovr = 1'b0;
    check("ovr_trim", 32'(trim), 17);
    check("ovr_valid", valid, 1);
    run_cal('{6'd44, 6'd44, 1'b1}, 1'b0);
`endif

    check("sb_drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/jnwatr_trim_sar.md
JNWATR_TRIM_SAR -- requirements
Module: jnwatr_trim_sar

Interface
REQ-001 Parameter NBITS, default 6: trim code width, one bit per binary-weighted transistor segment enable.
REQ-002 Parameter SETTLE, default 8: settle cycles per bit trial before the comparator is sampled; legal range 3..255.
REQ-003 CLK  input  1  single clock; all state changes on the rising edge.
REQ-004 RSTN  input  1  reset, synchronous and active-low.
REQ-005 START  input  1  level-sampled request to begin a calibration; ignored unless the state is IDLE.
REQ-006 ABORT  input  1  terminates any calibration in progress.
REQ-007 CMP  input  1  analog comparator output; asynchronous; 1 means the bank is above target.
REQ-008 TRIM  output  NBITS  segment-enable code driven to the transistor bank.
REQ-009 BUSY  output  1  high while calibrating (states SETTLE and DECIDE).
REQ-010 DONE  output  1  one-cycle pulse when a calibration completes.
REQ-011 VALID  output  1  high from completion until the next accepted START, ABORT or reset.

Function
REQ-012 CMP shall pass through a 2-flop synchronizer; only the synchronized value (CMPS) is used.
REQ-013 The FSM shall have states IDLE, SETTLE, DECIDE and FINISH; encoding is free.
REQ-014 IDLE->SETTLE on START=1 and ABORT=0, with these actions: TRIM = 1 in bit NBITS-1 and 0 elsewhere, bit index = NBITS-1, settle counter = SETTLE-1, VALID = 0.
REQ-015 SETTLE: the counter decrements every cycle; at counter 0 the next state is DECIDE.
REQ-016 DECIDE: if CMPS=1, clear TRIM[index]; otherwise keep it.
REQ-017 From DECIDE: if index=0, go to FINISH; otherwise decrement index, set TRIM[index-1], reload the counter with SETTLE-1 and go to SETTLE.
REQ-018 FINISH: DONE=1 and VALID set to 1 for one cycle, then IDLE; TRIM holds its final value.
REQ-019 Latency: if START is accepted at edge k, the first edge with DONE=1 is k+NBITS*(SETTLE+1)+1.
REQ-020 ABORT=1 in any state: next state IDLE, TRIM = midscale (bit NBITS-1 only), VALID=0, DONE=0.
REQ-021 ABORT takes priority over START and over a simultaneous DECIDE or FINISH.
REQ-022 START while BUSY=1 shall be ignored with no effect on the sequence.
REQ-023 START held high through FINISH shall be accepted in IDLE on the following cycle (back-to-back operation).
REQ-024 TRIM changes only in DECIDE, on accept, on abort or on reset, so each trial code is stable for SETTLE+1 cycles.

Reset
REQ-025 RSTN=0 at an edge: state IDLE, TRIM = midscale (32 for NBITS=6), BUSY=0, DONE=0, VALID=0, synchronizer flops 0, counter 0, index 0.
REQ-026 Reset asserted mid-calibration shall abandon the calibration with no DONE pulse; the first START after release is accepted normally.

Configuration
REQ-027 Macro JNWATR_TRIM_OVERRIDE_EN defined: add inputs OVR (1) and OVR_CODE (NBITS); OVR=1 in IDLE loads TRIM=OVR_CODE and sets VALID=1 on the next edge; OVR is ignored while BUSY=1.
REQ-028 Macro undefined: the OVR and OVR_CODE ports and their logic are absent; behaviour is identical to REQ-012..026.

Verification
REQ-029 Comparator model with CMP = (TRIM > 37), NBITS=6, SETTLE=8; START pulse at edge k -> TRIM=37, DONE at edge k+55, VALID=1.
REQ-030 Same model with target 0, then with target 63 -> final TRIM 0 and 63; the trial sequence for target 63 is 32, 48, 56, 60, 62, 63.
REQ-031 ABORT during the trial of bit 3 (TRIM=40 under target 37) -> next edge TRIM=32, BUSY=0, VALID=0, and no DONE pulse.
REQ-032 RSTN low for 1 cycle mid-calibration, then START -> post-reset values per REQ-025, and the new calibration completes with the correct code and latency.
REQ-033 START held high continuously -> back-to-back calibrations with DONE pulses exactly NBITS*(SETTLE+1)+2 cycles apart; extra START pulses while BUSY=1 are ignored.
REQ-034 With JNWATR_TRIM_OVERRIDE_EN: OVR=1 with OVR_CODE=17 in IDLE -> TRIM=17, VALID=1; OVR=1 while BUSY=1 -> no effect.
